ssd_scan_decoder: RTL and testbench

- Reads a multiplexed, active-low seven-segment display bus (segment lines plus per-digit select lines) and recovers the displayed BCD digits.
- Filters scan glitches and collects one complete frame of NUM_DIGITS digits.
- Presents each frame on a valid/ready output.
- Used as the read-back/monitor end of the display path, e.g. self-checking display output on the board or in simulation.

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_pattern_decode.sv | 42 ++++
 rtl/ssd_scan_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants and types for the seven-segment scan decoder.
//   SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   CODE_BLANK   : code reported for a dark digit
//   CODE_INVALID : code reported for an unrecognised pattern
//   state_e      : frame FSM states
// Optional feature macro: SSD_HEX_DECODE_EN adds the A..F glyph patterns.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef SSD_HEX_DECODE_EN
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
`endif

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode -- combinational segment pattern to digit code lookup.
//   seg_n_i   in  7  active-low segment pattern {g,f,e,d,c,b,a}
//   code_o    out 4  decoded digit code (0..9, 0xF blank, 0xE unrecognised)
//   invalid_o out 1  pattern not in the table
// Optional feature macro: SSD_HEX_DECODE_EN decodes the A..F glyphs to 0xA..0xF.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] code_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = CODE_INVALID;
    invalid_o = 1'b0;
    case (seg_n_i)
      SEG_0:     code_o = 4'h0;
      SEG_1:     code_o = 4'h1;
      SEG_2:     code_o = 4'h2;
      SEG_3:     code_o = 4'h3;
      SEG_4:     code_o = 4'h4;
      SEG_5:     code_o = 4'h5;
      SEG_6:     code_o = 4'h6;
      SEG_7:     code_o = 4'h7;
      SEG_8:     code_o = 4'h8;
      SEG_9:     code_o = 4'h9;
      SEG_BLANK: code_o = CODE_BLANK;
`ifdef SSD_HEX_DECODE_EN
      SEG_A:     code_o = 4'hA;
      SEG_B:     code_o = 4'hB;
      SEG_C:     code_o = 4'hC;
      SEG_D:     code_o = 4'hD;
      SEG_E:     code_o = 4'hE;
      // Same code as blank; only the driven pattern tells them apart.
      SEG_F:     code_o = 4'hF;
`endif
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder -- recovers the digits shown on a multiplexed, active-low
// seven-segment bus and presents each complete frame on a valid/ready port.
//   clk        in   1             system clock
//   rst_n      in   1             asynchronous active-low reset
//   seg_n      in   7             segment lines, active-low {g,f,e,d,c,b,a}
//   sel_n      in   NUM_DIGITS    digit selects, active-low, one-hot when valid
//   clear      in   1             synchronous flush of frame, outputs and flags
//   ready_i    in   1             consumer accepts value_o
//   valid_o    out  1             frame available
//   value_o    out  4*NUM_DIGITS  digit codes, digit i in [4i+3:4i]
//   invalid_o  out  NUM_DIGITS    per-digit unrecognised-pattern flags
//   overrun_o  out  1             sticky: a completed frame was dropped
// Optional feature macro: SSD_HEX_DECODE_EN (hex glyphs in ssd_pattern_decode).
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   sel_n,
  input  logic                    clear,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   invalid_o,
  output logic                    overrun_o
);

  localparam int         SW        = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_N  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------- sync
  // Flops reset to all-ones, the idle (dark, deselected) bus level, so the
  // filter never sees a phantom selected digit coming out of reset.
  logic [6:0]            seg_meta_q, seg_sync_q;
  logic [NUM_DIGITS-1:0] sel_meta_q, sel_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      sel_meta_q <= '1;
      sel_sync_q <= '1;
    end else begin
      seg_meta_q <= seg_n;
      seg_sync_q <= seg_meta_q;
      sel_meta_q <= sel_n;
      sel_sync_q <= sel_meta_q;
    end
  end

  // ------------------------------------------------------ stability filter
  logic [SW-1:0]         samp, samp_prev_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  samp_same;
  logic [NUM_DIGITS-1:0] sel_act;
  logic                  sel_onehot;
  logic                  accept;

  assign samp       = {sel_sync_q, seg_sync_q};
  assign samp_same  = (samp == samp_prev_q);
  assign sel_act    = ~sel_sync_q;
  assign sel_onehot = (sel_act != '0) &&
                      ((sel_act & (sel_act - NUM_DIGITS'(1))) == '0);
  // Fires only on the transition into saturation, so a held digit is
  // accepted once and re-arms only when the sample changes.
  assign accept     = !clear && samp_same && (cnt_q == STABLE_M1) && sel_onehot;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!samp_same) begin
      cnt_d = 8'd1;
    end else if (cnt_q != STABLE_N) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_prev_q <= '1;
      cnt_q       <= '0;
    end else begin
      samp_prev_q <= samp;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [3:0] dec_code;
  logic       dec_invalid;

  ssd_pattern_decode u_decode (
    .seg_n_i   (seg_sync_q),
    .code_o    (dec_code),
    .invalid_o (dec_invalid)
  );

  // ---------------------------------------------------------- frame buffer
  logic [NUM_DIGITS-1:0]   wr_en;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] buf_code_q;
  logic [NUM_DIGITS-1:0]   buf_inv_q;
  logic                    seen_full;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr
    assign wr_en[gi] = accept & sel_act[gi];
  end

  assign seen_full = &seen_q;

  // Every completion (load, reload or drop) starts a fresh frame; an accept
  // on that same edge belongs to the new frame and is kept.
  always_comb begin
    seen_d = seen_q;
    if (clear) begin
      seen_d = '0;
    end else begin
      if (seen_full) seen_d = '0;
      seen_d = seen_d | wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= '0;
      buf_code_q <= '0;
      buf_inv_q  <= '0;
    end else begin
      seen_q <= seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en[i]) begin
          buf_code_q[4*i +: 4] <= dec_code;
          buf_inv_q[i]         <= dec_invalid;
        end
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  state_e state_q, state_d;
  logic   load_out;
  logic   set_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    set_ovr  = 1'b0;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (seen_full) begin
            load_out = 1'b1;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (ready_i) begin
            if (seen_full) load_out = 1'b1;
            else           state_d  = COLLECT;
          end else if (seen_full) begin
            set_ovr = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   invalid_q;
  logic                    overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      invalid_q <= '0;
      overrun_q <= 1'b0;
    end else if (clear) begin
      value_q   <= '0;
      invalid_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load_out) begin
        value_q   <= buf_code_q;
        invalid_q <= buf_inv_q;
      end
      if (set_ovr) overrun_q <= 1'b1;
    end
  end

  assign valid_o   = (state_q == HOLD);
  assign value_o   = value_q;
  assign invalid_o = invalid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder -- directed bench for ssd_scan_decoder (defaults:
// 4 digits, 4 stable cycles). Honours SSD_HEX_DECODE_EN for the hex vector.
module tb_ssd_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  sel_n;
  logic        clear;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] value_o;
  logic [3:0]  invalid_o;
  logic        overrun_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          frame_cnt = 0;
  logic [15:0] last_val = '0;
  logic [3:0]  last_inv = '0;

  ssd_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .sel_n     (sel_n),
    .clear     (clear),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .value_o   (value_o),
    .invalid_o (invalid_o),
    .overrun_o (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per accepted frame (valid & ready seen before the edge).
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      frame_cnt = frame_cnt + 1;
      last_val  = value_o;
      last_inv  = invalid_o;
      $display("frame %0d: value=%h invalid=%b overrun=%b",
               frame_cnt, value_o, invalid_o, overrun_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [6:0] seg, input int n);
    logic [3:0] oh;
    oh    = 4'b0001 << idx;
    sel_n = ~oh;
    seg_n = seg;
    tick(n);
  endtask

  task automatic blank(input int n);
    sel_n = 4'hF;
    seg_n = 7'h7F;
    tick(n);
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_n   = 7'h7F;
    sel_n   = 4'hF;
    clear   = 1'b0;
    ready_i = 1'b1;
    tick(3);
    check("rst_valid",   32'(valid_o),   32'h0);
    check("rst_value",   32'(value_o),   32'h0);
    check("rst_invalid", 32'(invalid_o), 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Frame 3,0,2,1 with exact latency: 2 sync + 4 stable -> accept on the
    // 6th edge, valid after the 7th.
    drive(0, 7'b0110000, 8);
    drive(1, 7'b1000000, 8);
    drive(2, 7'b0100100, 8);
    drive(3, 7'b1111001, 6);
    check("lat_valid_early", 32'(valid_o), 32'h0);
    tick(1);
    check("lat_valid",   32'(valid_o),   32'h1);
    check("f1_value",    32'(value_o),   32'h1203);
    check("f1_invalid",  32'(invalid_o), 32'h0);
    tick(1);
    check("f1_valid_drop", 32'(valid_o), 32'h0);
    blank(8);
    check("f1_count",    32'(frame_cnt), 32'd1);

    // Short holds (3 cycles) and bad selects must not set any seen bit.
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        drive(d, 7'b0000000, 3);
    blank(8);
    sel_n = 4'b1100;
    seg_n = 7'b0000000;
    tick(8);
    blank(8);
    drive(0, 7'b0010000, 8);
    drive(1, 7'b0000000, 8);
    drive(2, 7'b1111000, 8);
    blank(8);
    check("glitch_no_valid", 32'(valid_o),   32'h0);
    check("glitch_no_frame", 32'(frame_cnt), 32'd1);
    drive(3, 7'b0000010, 8);
    blank(8);
    check("f2_count", 32'(frame_cnt), 32'd2);
    check("f2_value", 32'(last_val),  32'h6789);

    // Unrecognised pattern on digit 0, blank on digit 2.
    drive(0, 7'b1010101, 8);
    drive(1, 7'b0010010, 8);
    drive(2, 7'b1111111, 8);
    drive(3, 7'b0010000, 8);
    blank(8);
    check("f3_count",   32'(frame_cnt), 32'd3);
    check("f3_value",   32'(last_val),  32'h9F5E);
    check("f3_invalid", 32'(last_inv),  32'h1);

    // Hex glyphs A,b,C,d.
    drive(0, 7'b0001000, 8);
    drive(1, 7'b0000011, 8);
    drive(2, 7'b1000110, 8);
    drive(3, 7'b0100001, 8);
    blank(8);
    check("hex_count", 32'(frame_cnt), 32'd4);
`ifdef SSD_HEX_DECODE_EN
    check("hex_value",   32'(last_val), 32'hDCBA);
    check("hex_invalid", 32'(last_inv), 32'h0);
`else
    check("hex_value",   32'(last_val), 32'hEEEE);
    check("hex_invalid", 32'(last_inv), 32'hF);
`endif

    // Reset mid-frame discards digits 0,1.
    drive(0, 7'b1111000, 8);
    drive(1, 7'b1111000, 8);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_value", 32'(value_o), 32'h0);
    rst_n = 1'b1;
    drive(2, 7'b0011001, 8);
    drive(3, 7'b0010010, 8);
    blank(8);
    check("mid_rst_partial", 32'(frame_cnt), 32'd4);
    drive(0, 7'b1000000, 8);
    drive(1, 7'b0000010, 8);
    blank(8);
    check("f5_count", 32'(frame_cnt), 32'd5);
    check("f5_value", 32'(last_val),  32'h5460);

    // Back-pressure: frame held, second frame dropped, then clear.
    ready_i = 1'b0;
    drive(0, 7'b0011001, 8);
    drive(1, 7'b0000010, 8);
    drive(2, 7'b1111000, 8);
    drive(3, 7'b0000000, 8);
    blank(8);
    check("bp_valid",       32'(valid_o),   32'h1);
    check("bp_value",       32'(value_o),   32'h8764);
    check("bp_overrun_pre", 32'(overrun_o), 32'h0);
    for (int d = 0; d < 4; d++)
      drive(d, 7'b1111001, 8);
    blank(8);
    check("ovr_valid",   32'(valid_o),   32'h1);
    check("ovr_value",   32'(value_o),   32'h8764);
    check("ovr_flag",    32'(overrun_o), 32'h1);
    check("ovr_no_xfer", 32'(frame_cnt), 32'd5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_valid",   32'(valid_o),   32'h0);
    check("clr_overrun", 32'(overrun_o), 32'h0);
    check("clr_value",   32'(value_o),   32'h0);
    tick(4);
    check("clr_stays",   32'(valid_o),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
